buf_fifo: RTL and testbench

Parametrised elastic datapath buffer that replaces fixed-delay wire buffers between datapath stages. Holds up to DEPTH words of SIZE bits in first-in-first-out order behind valid/ready handshakes on both sides. Gives backpressure, occupancy reporting, an almost-full threshold and a synchronous flush. Sits between a producing stage (ALU/register-file side) and a consuming stage that may stall.

---
 rtl/buf_fifo_pkg.sv | 32 +++
 rtl/buf_fifo_if.sv | 40 ++++
 rtl/buf_ptr.sv | 43 ++++
 rtl/buf_fifo.sv | 114 +++++++++++
 tb/tb_buf_fifo.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/buf_fifo_pkg.sv
// ---------------------------------------------------------------------------
// buf_fifo_pkg
// Shared definitions for the elastic datapath buffers.
//   clog2()   : ceiling log2, usable in parameter/port-width expressions
//   ptr_w()   : pointer width needed to address DEPTH entries
//   DEF_SIZE  : default data word width
//   DEF_DEPTH : default number of storage entries
// ---------------------------------------------------------------------------
package buf_fifo_pkg;

    localparam int DEF_SIZE  = 32;
    localparam int DEF_DEPTH = 4;

    // Ceiling log2; clog2(1) = 0, clog2(4) = 2, clog2(5) = 3.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // DEPTH is a power of two >= 2, so this is always at least 1 bit.
    function automatic int ptr_w(input int depth);
        return clog2(depth);
    endfunction

endpackage

// File: rtl/buf_fifo_if.sv
// ---------------------------------------------------------------------------
// buf_fifo_if
// Bundles the two valid/ready streams of the buffer.
//   in_data/in_valid/in_ready    : write side (producer -> buffer)
//   out_data/out_valid/out_ready : read side (buffer -> consumer)
// Handshake: a word moves on a rising edge exactly when valid and ready are
// both high in that cycle. Ready/valid driven by the buffer depend only on
// its registered state, never combinationally on the opposite valid/ready.
// Modports:
//   slave  : the buffer itself
//   master : the environment (producer and consumer together)
// ---------------------------------------------------------------------------
interface buf_fifo_if #(
    parameter int SIZE = 32
);
    logic [SIZE-1:0] in_data;
    logic            in_valid;
    logic            in_ready;
    logic [SIZE-1:0] out_data;
    logic            out_valid;
    logic            out_ready;

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/buf_ptr.sv
// ---------------------------------------------------------------------------
// buf_ptr
// Wrapping pointer counter used for the read and write pointers.
//   clk    : clock
//   rst_n  : asynchronous active-low reset (pointer -> 0)
//   clr_i  : synchronous clear, wins over inc_i
//   inc_i  : advance pointer by one, wrapping modulo 2**WIDTH
//   ptr_o  : current pointer value
// ---------------------------------------------------------------------------
module buf_ptr #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] ptr_o
);

    logic [WIDTH-1:0] ptr_q;
    logic [WIDTH-1:0] ptr_d;

    // Depth is a power of two, so natural binary overflow is the wrap.
    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = ptr_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/buf_fifo.sv
// ---------------------------------------------------------------------------
// buf_fifo
// Elastic first-word-fall-through buffer between two datapath stages.
// Holds up to DEPTH words of SIZE bits.
//   clk         : clock, all state changes on rising edge
//   rst_n       : asynchronous active-low reset; clears pointers, count and
//                 storage
//   flush       : synchronous discard of all stored words; beats push/pop
//   bus         : slave side of buf_fifo_if (in_* write, out_* read)
//   count       : occupancy 0..DEPTH
//   full        : count == DEPTH
//   empty       : count == 0
//   almost_full : count >= AF_LEVEL
// ---------------------------------------------------------------------------
module buf_fifo
    import buf_fifo_pkg::*;
#(
    parameter int SIZE     = DEF_SIZE,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    buf_fifo_if.slave              bus,
    output logic [clog2(DEPTH):0]  count,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = clog2(DEPTH) + 1;

    logic [SIZE-1:0] mem_q [DEPTH];
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic            push;
    logic            pop;
    logic            wr_inc;
    logic            rd_inc;

    // Flags come straight from the registered count, so ready/valid never
    // form a combinational path from in_valid/out_ready.
    assign full        = (count_q == CW'(DEPTH));
    assign empty       = (count_q == '0);
    assign almost_full = (count_q >= CW'(AF_LEVEL));
    assign count       = count_q;

    assign bus.in_ready  = ~full;
    assign bus.out_valid = ~empty;
    assign bus.out_data  = mem_q[rd_ptr];

    assign push = bus.in_valid & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;

    // A flush discards any push/pop seen in the same cycle.
    assign wr_inc = push & ~flush;
    assign rd_inc = pop & ~flush;

    buf_ptr #(.WIDTH(PW)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (flush),
        .inc_i (wr_inc),
        .ptr_o (wr_ptr)
    );

    buf_ptr #(.WIDTH(PW)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (flush),
        .inc_i (rd_inc),
        .ptr_o (rd_ptr)
    );

    // Occupancy kept as its own register so full vs. empty is unambiguous
    // when the pointers are equal.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Storage is zeroed on reset so out_data reads 0 right after reset;
    // a flush leaves contents alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_inc) begin
            mem_q[wr_ptr] <= bus.in_data;
        end
    end

endmodule

// File: tb/tb_buf_fifo.sv
// ---------------------------------------------------------------------------
// tb_buf_fifo
// Directed, table-driven bench for buf_fifo (SIZE=32, DEPTH=4, AF_LEVEL=3),
// plus hand-written sequences for reset, streaming, wrap and reset mid-stream.
// ---------------------------------------------------------------------------
module tb_buf_fifo;

    localparam int SIZE  = 32;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       almost_full;

    int errors;
    int checks;

    buf_fifo_if #(.SIZE(SIZE)) bus ();

    buf_fifo #(.SIZE(SIZE), .DEPTH(DEPTH), .AF_LEVEL(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .bus         (bus),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- vector record ----------------
    typedef struct {
        logic        iv;
        logic        ordy;
        logic        fl;
        logic [31:0] din;
        logic [2:0]  e_cnt;
        logic        e_ov;
        logic [31:0] e_od;
        logic        e_full;
        logic        e_empty;
        logic        e_af;
        logic        e_ir;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    // ---------------- checker ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input logic [2:0] e_cnt, input logic e_ov,
                             input logic e_full, input logic e_empty, input logic e_af,
                             input logic e_ir);
        chk({tag, ".count"},       32'(count),         32'(e_cnt));
        chk({tag, ".out_valid"},   32'(bus.out_valid), 32'(e_ov));
        chk({tag, ".full"},        32'(full),          32'(e_full));
        chk({tag, ".empty"},       32'(empty),         32'(e_empty));
        chk({tag, ".almost_full"}, 32'(almost_full),   32'(e_af));
        chk({tag, ".in_ready"},    32'(bus.in_ready),  32'(e_ir));
    endtask

    // ---------------- drivers ----------------
    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // at the same point, after the edge that consumed the previous inputs.
    task automatic drive(input logic iv, input logic ordy, input logic fl, input logic [31:0] din);
        bus.in_valid  = iv;
        bus.out_ready = ordy;
        flush         = fl;
        bus.in_data   = din;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        step();
        step();
        rst_n = 1'b1;
    endtask

    // ---------------- test ----------------
    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        idle();

        //            iv ordy fl din           cnt ov od           full emp af ir
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h1, 3'd1, 1'b1, 32'h1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h2, 3'd2, 1'b1, 32'h1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h3, 3'd3, 1'b1, 32'h1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h4, 3'd4, 1'b1, 32'h1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h5, 3'd4, 1'b1, 32'h1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h0, 3'd3, 1'b1, 32'h2, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h0, 3'd2, 1'b1, 32'h3, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'h6, 3'd2, 1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h0, 3'd1, 1'b1, 32'h6, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h0, 3'd0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h0, 3'd0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 32'h7, 3'd1, 1'b1, 32'h7, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 32'h8, 3'd2, 1'b1, 32'h7, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 1'b1, 1'b1, 32'h9, 3'd0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 32'hA, 3'd1, 1'b1, 32'hA, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 32'h0, 3'd0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1};

        // Reset state, checked while reset is held.
        step();
        chk_flags("reset", 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("reset.out_data", bus.out_data, 32'h0);
        rst_n = 1'b1;

        // Table: fill, overflow attempt, drain, empty pop, flush priority.
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].iv, vecs[i].ordy, vecs[i].fl, vecs[i].din);
            step();
            chk_flags($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_ov,
                      vecs[i].e_full, vecs[i].e_empty, vecs[i].e_af, vecs[i].e_ir);
            if (vecs[i].e_ov) begin
                chk($sformatf("vec%0d.out_data", i), bus.out_data, vecs[i].e_od);
            end
        end
        idle();
        step();

        // Streaming: one word per cycle, each visible one cycle after push.
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, 1'b1, 1'b0, 32'(k));
            step();
            chk($sformatf("stream%0d.out_data", k), bus.out_data, 32'(k));
            chk($sformatf("stream%0d.count", k), 32'(count), 32'd1);
            chk($sformatf("stream%0d.out_valid", k), 32'(bus.out_valid), 32'd1);
        end
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        step();
        chk("stream_end.count", 32'(count), 32'd0);
        idle();

        // Wrap: full FIFO with pop + push offered; only the pop happens.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h10 + 32'(k));
            step();
        end
        chk_flags("wrap_full", 3'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("wrap_full.out_data", bus.out_data, 32'h10);
        drive(1'b1, 1'b1, 1'b0, 32'h55);
        step();
        chk("wrap_pop.count", 32'(count), 32'd3);
        chk("wrap_pop.out_data", bus.out_data, 32'h11);
        drive(1'b1, 1'b0, 1'b0, 32'h55);
        step();
        chk("wrap_push.count", 32'(count), 32'd4);
        begin
            logic [31:0] exp_q[$];
            exp_q = '{32'h11, 32'h12, 32'h13, 32'h55};
            drive(1'b0, 1'b1, 1'b0, 32'h0);
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("wrap_drain%0d.out_valid", k), 32'(bus.out_valid), 32'd1);
                chk($sformatf("wrap_drain%0d.out_data", k), bus.out_data, exp_q.pop_front());
                step();
            end
            chk("wrap_drain.empty", 32'(empty), 32'd1);
        end
        idle();
        step();

        // Reset mid-stream takes effect without waiting for an edge.
        drive(1'b1, 1'b0, 1'b0, 32'hA5A5A5A5);
        step();
        drive(1'b1, 1'b0, 1'b0, 32'h1);
        step();
        chk("mid.count_before", 32'(count), 32'd2);
        rst_n = 1'b0;
        #1;
        chk_flags("midrst", 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("midrst.out_data", bus.out_data, 32'h0);
        idle();
        do_reset();

        // First push after reset release is accepted.
        drive(1'b1, 1'b0, 1'b0, 32'hCAFE0001);
        step();
        chk("post_rst.count", 32'(count), 32'd1);
        chk("post_rst.out_data", bus.out_data, 32'hCAFE0001);
        idle();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
